// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the radix-2 restoring divider.
//   DIV_W   default operand/result width
//   state_e divider FSM encoding (IDLE -> BUSY -> DONE -> IDLE)
package div_unit_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the execute stage.
// Quotient goes to LO, remainder goes to HI. stall_div freezes F/D/E while
// the divider iterates.
// Ports:
//   clk, rst          clock, async active-high reset
//   start, signed_op  begin a divide (DIV when signed_op=1, DIVU otherwise)
//   annul             abort whatever is in flight; wins over start
//   a, b              dividend and divisor, captured on accept
//   stall_div         hazard-unit stall request
//   done              one-cycle pulse; quotient/remainder are valid
//   quotient          held until the next done
//   remainder         held until the next done
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall_div,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend, shifted out as quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_iter;
  logic             q_bit;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, rem_sub;     // one extra bit: 2*rem+1 can exceed WIDTH bits
  logic [WIDTH-1:0] rem_next, q_next;

  always_comb begin
    accept    = (state_q == S_IDLE) && start && !annul;
    last_iter = (count_q == CW'(WIDTH - 1));

    a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag = (signed_op && b[WIDTH-1]) ? -b : b;

    // One restoring step. A zero divisor always "fits", which yields
    // q = all-ones and r = |a| without any special casing.
    rem_sh   = {rem_q, dvd_q[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, dvs_q};
    q_bit    = (rem_sh >= {1'b0, dvs_q});
    rem_next = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    q_next   = {dvd_q[WIDTH-2:0], q_bit};

    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    sgnq_d      = sgnq_q;
    sgnr_d      = sgnr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          count_d = '0;
          rem_d   = '0;
          dvd_d   = a_mag;
          dvs_d   = b_mag;
          sgnq_d  = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
          sgnr_d  = signed_op && a[WIDTH-1];
        end
      end
      S_BUSY: begin
        rem_d   = rem_next;
        dvd_d   = q_next;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          // Result registers load on the edge into DONE, so they are
          // valid for the whole cycle that done is high.
          state_d     = S_DONE;
          quotient_d  = sgnq_q ? -q_next : q_next;
          remainder_d = sgnr_q ? -rem_next : rem_next;
          done_d      = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (annul) begin
      state_d     = S_IDLE;
      count_d     = '0;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      sgnq_q      <= 1'b0;
      sgnr_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      sgnq_q      <= sgnq_d;
      sgnr_q      <= sgnr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
    end
  end

  // Stall is raised combinationally in the accept cycle so the operands in E
  // are not lost, and dropped in DONE so HI/LO write as the pipe advances.
  assign stall_div = accept || (state_q == S_BUSY);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector bench for div_unit with hand-computed results.
module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic         annul;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         stall_div;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_cmp = 0;
  int n_err = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .annul     (annul),
    .a         (a),
    .b         (b),
    .stall_div (stall_div),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is positioned #1 after a rising edge with the divider idle.
  task automatic run_div(input string tag, input logic sg, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] eq,
                         input logic [W-1:0] er);
    int lat;
    int stalls;
    start = 1'b1; signed_op = sg; a = av; b = bv;
    #1;
    stalls = stall_div ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    lat = 0;
    while (!done && lat < 100) begin
      if (stall_div) stalls++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(W));
    chk({tag, "_stalls"}, 64'(stalls), 64'(W + 1));
    chk({tag, "_stall_done"}, 64'(stall_div), 64'd0);
    chk({tag, "_q"}, 64'(quotient), 64'(eq));
    chk({tag, "_r"}, 64'(remainder), 64'(er));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; annul = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_stall", 64'(stall_div), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(quotient), 64'd0);
    chk("rst_r", 64'(remainder), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("divu_5_0",   1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    run_div("divu_big",   1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1);
    run_div("divu_100_7b", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    // Annul in the 10th BUSY cycle.
    start = 1'b1; signed_op = 1'b0; a = 32'd50; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    annul = 1'b1;
    #1;
    chk("annul_stall_hi", 64'(stall_div), 64'd1);
    @(posedge clk); #1;
    annul = 1'b0;
    #1;
    chk("annul_stall_lo", 64'(stall_div), 64'd0);
    chk("annul_done", 64'(done), 64'd0);
    chk("annul_q_keep", 64'(quotient), 64'd14);
    chk("annul_r_keep", 64'(remainder), 64'd2);
    run_div("after_annul", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2);

    // annul beats start in the same cycle.
    start = 1'b1; annul = 1'b1; a = 32'd8; b = 32'd2;
    #1;
    chk("annul_vs_start_stall", 64'(stall_div), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    #1;
    chk("annul_vs_start_idle", 64'(stall_div), 64'd0);

    // start held high through BUSY: exactly one done.
    start = 1'b1; signed_op = 1'b0; a = 32'd1000; b = 32'd10;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("held_lat", 64'(lat), 64'(W));
    chk("held_q", 64'(quotient), 64'd100);
    chk("held_r", 64'(remainder), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    chk("held_single_done", 64'(done), 64'd0);
    chk("held_idle", 64'(stall_div), 64'd0);
    run_div("back_to_back", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

    // Async reset mid-BUSY.
    start = 1'b1; signed_op = 1'b0; a = 32'd77; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stall", 64'(stall_div), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_q", 64'(quotient), 64'd0);
    chk("arst_r", 64'(remainder), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_no_done", 64'(done), 64'd0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
